// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for a combinational 16-bit ALU: register file, operand drive,
// result capture, writeback and status flags, with a four-state IDLE/OPRD/EXEC/WB sequence.
module alu_exec_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    input  logic [DATA_W-1:0] imm_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_select,
    output logic              alu_mode,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    input  logic              alu_cmp,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              cmp_flag,
    output logic              done,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned NumRegs = 1 << REG_AW;

    typedef enum logic [1:0] {StIdle, StOprd, StExec, StWb} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] regs_q [NumRegs];

    // Latched instruction fields
    logic              ldi_q;
    logic              mode_q;
    logic [3:0]        sel_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] ra_q;
    logic [REG_AW-1:0] rb_q;
    logic              use_carry_q;
    logic [DATA_W-1:0] imm_q;

    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [3:0]        alu_sel_q;
    logic              alu_mode_q;
    logic              alu_cin_q;

    logic [DATA_W-1:0] res_q;
    logic              cout_q;
    logic              cmp_q;

    logic              carry_q;
    logic              zero_q;
    logic              cmpf_q;

    logic              accept;
    logic [DATA_W-1:0] wb_data;

    assign accept  = instr_valid && (state_q == StIdle);
    assign wb_data = ldi_q ? imm_q : res_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    state_d = instr[15] ? StWb : StOprd;
                end
            end
            StOprd:  state_d = StExec;
            StExec:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        instr_ready = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            StIdle:  instr_ready = 1'b1;
            StWb:    done        = 1'b1;
            default: ;
        endcase
    end

    // Instruction latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ldi_q       <= 1'b0;
            mode_q      <= 1'b0;
            sel_q       <= '0;
            rd_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            use_carry_q <= 1'b0;
            imm_q       <= '0;
        end else if (accept) begin
            ldi_q       <= instr[15];
            mode_q      <= instr[14];
            sel_q       <= instr[13:10];
            rd_q        <= instr[9:7];
            ra_q        <= instr[6:4];
            rb_q        <= instr[3:1];
            use_carry_q <= instr[0];
            if (instr[15]) begin
                imm_q <= imm_data;
            end
        end
    end

    // ALU drive registers; they hold outside OPRD so the ALU sees stable inputs through EXEC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            alu_mode_q <= 1'b0;
            alu_cin_q  <= 1'b0;
        end else if (state_q == StOprd) begin
            alu_a_q    <= regs_q[ra_q];
            alu_b_q    <= regs_q[rb_q];
            alu_sel_q  <= sel_q;
            alu_mode_q <= mode_q;
            alu_cin_q  <= use_carry_q & carry_q;
        end
    end

    // Result capture at the end of EXEC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q  <= '0;
            cout_q <= 1'b0;
            cmp_q  <= 1'b0;
        end else if (state_q == StExec) begin
            res_q  <= alu_result;
            cout_q <= alu_cout;
            cmp_q  <= alu_cmp;
        end
    end

    // Writeback: register file and flags (flags untouched by ldi)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            cmpf_q  <= 1'b0;
        end else if (state_q == StWb) begin
            regs_q[rd_q] <= wb_data;
            if (!ldi_q) begin
                carry_q <= cout_q;
                zero_q  <= (res_q == '0);
                cmpf_q  <= cmp_q;
            end
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_select = alu_sel_q;
    assign alu_mode   = alu_mode_q;
    assign alu_cin    = alu_cin_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;
    assign cmp_flag   = cmpf_q;
    assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a small behavioural ALU closing the loop.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [15:0] imm_data = '0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_select;
    logic        alu_mode;
    logic        alu_cin;
    logic [15:0] alu_result;
    logic        alu_cout;
    logic        alu_cmp;
    logic        carry_flag;
    logic        zero_flag;
    logic        cmp_flag;
    logic        done;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.DATA_W(16), .REG_AW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .imm_data   (imm_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_select (alu_select),
        .alu_mode   (alu_mode),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .alu_cmp    (alu_cmp),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .cmp_flag   (cmp_flag),
        .done       (done),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Behavioural ALU: arithmetic 1001 = A+B+cin, logic 0110 = XOR, 1011 = AND, 1110 = OR
    always_comb begin
        alu_result = '0;
        alu_cout   = 1'b0;
        alu_cmp    = (alu_a == alu_b);
        if (!alu_mode) begin
            if (alu_select == 4'b1001) begin
                {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
            end else begin
                {alu_cout, alu_result} = {1'b0, alu_a} + {16'd0, alu_cin};
            end
        end else begin
            case (alu_select)
                4'b0110: alu_result = alu_a ^ alu_b;
                4'b1011: alu_result = alu_a & alu_b;
                4'b1110: alu_result = alu_a | alu_b;
                default: alu_result = ~alu_a;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] enc(input logic ldi, input logic mode, input logic [3:0] sel,
                                        input logic [2:0] rd, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic uc);
        return {ldi, mode, sel, rd, ra, rb, uc};
    endfunction

    // Offer one instruction and leave it accepted (state just past the accept edge).
    task automatic issue(input logic [15:0] ins, input logic [15:0] imm);
        int n;
        n = 0;
        while (!instr_ready && n < 8) begin
            step();
            n++;
        end
        if (!instr_ready) chk("ready_timeout", 32'(instr_ready), 32'd1);
        instr       = ins;
        imm_data    = imm;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic load_imm(input logic [2:0] rd, input logic [15:0] val);
        issue(enc(1'b1, 1'b0, 4'd0, rd, 3'd0, 3'd0, 1'b0), val);
        step();
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] addr, input logic [15:0] exp);
        dbg_addr = addr;
        #1;
        chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    task automatic chk_flags(input string tag, input logic c, input logic z, input logic m);
        chk({tag, "_carry"}, 32'(carry_flag), 32'(c));
        chk({tag, "_zero"}, 32'(zero_flag), 32'(z));
        chk({tag, "_cmp"}, 32'(cmp_flag), 32'(m));
    endtask

    logic [11:0] rdy_v;
    logic [11:0] done_v;
    logic        acc;
    int          nacc;
    int          ndone;

    initial begin
        // 1: reset
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk_reg($sformatf("rst_r%0d", i), 3'(i), 16'h0000);
        end

        // 2: FFFF + 0001 wraps to zero with carry out
        load_imm(3'd1, 16'hFFFF);
        load_imm(3'd2, 16'h0001);
        chk_reg("ldi_r1", 3'd1, 16'hFFFF);
        issue(enc(1'b0, 1'b0, 4'b1001, 3'd3, 3'd1, 3'd2, 1'b0), 16'h0);
        chk("t2_oprd_done", 32'(done), 32'd0);
        step();
        chk("t2_exec_a", 32'(alu_a), 32'h0000FFFF);
        chk("t2_exec_b", 32'(alu_b), 32'h00000001);
        chk("t2_exec_cin", 32'(alu_cin), 32'd0);
        step();
        chk("t2_wb_done", 32'(done), 32'd1);
        step();
        chk("t2_idle_done", 32'(done), 32'd0);
        chk_reg("t2_r3", 3'd3, 16'h0000);
        chk_flags("t2", 1'b1, 1'b1, 1'b0);

        // 3: carry-in from previous carry, rd/ra/rb with ra==rb
        load_imm(3'd4, 16'h0010);
        chk_flags("ldi_keeps", 1'b1, 1'b1, 1'b0);
        issue(enc(1'b0, 1'b0, 4'b1001, 3'd5, 3'd4, 3'd4, 1'b1), 16'h0);
        step();
        chk("t3_exec_cin", 32'(alu_cin), 32'd1);
        step();
        step();
        chk_reg("t3_r5", 3'd5, 16'h0021);
        chk_flags("t3", 1'b0, 1'b0, 1'b1);

        // 4: logic XOR
        issue(enc(1'b0, 1'b1, 4'b0110, 3'd6, 3'd1, 3'd2, 1'b0), 16'h0);
        step();
        chk("t4_exec_mode", 32'(alu_mode), 32'd1);
        chk("t4_exec_sel", 32'(alu_select), 32'h6);
        step();
        step();
        chk_reg("t4_r6", 3'd6, 16'hFFFE);
        chk_flags("t4", 1'b0, 1'b0, 1'b0);

        // 5: back-to-back with valid held; second reads r0 written by the first
        instr       = enc(1'b0, 1'b1, 4'b0110, 3'd0, 3'd1, 3'd4, 1'b0);
        instr_valid = 1'b1;
        nacc        = 0;
        for (int i = 0; i < 12; i++) begin
            acc = instr_ready && instr_valid;
            step();
            rdy_v[i]  = instr_ready;
            done_v[i] = done;
            if (acc) begin
                nacc++;
                if (nacc == 1) instr = enc(1'b0, 1'b0, 4'b1001, 3'd2, 3'd0, 3'd0, 1'b0);
                else instr_valid = 1'b0;
            end
        end
        instr_valid = 1'b0;
        chk("t5_ready_pattern", 32'(rdy_v), 32'(12'b1111_1000_1000));
        chk("t5_done_pattern", 32'(done_v), 32'(12'b0000_0100_0100));
        chk("t5_accepts", 32'(nacc), 32'd2);
        chk_reg("t5_r0", 3'd0, 16'hFFEF);
        chk_reg("t5_r2", 3'd2, 16'hFFDE);
        chk_flags("t5", 1'b1, 1'b0, 1'b1);

        // 6: reset during EXEC drops the instruction
        load_imm(3'd7, 16'h1234);
        chk_reg("t6_r7_pre", 3'd7, 16'h1234);
        chk("t6_ldi_carry", 32'(carry_flag), 32'd1);
        issue(enc(1'b0, 1'b0, 4'b1001, 3'd7, 3'd1, 3'd2, 1'b0), 16'h0);
        step();
        chk("t6_exec_a", 32'(alu_a), 32'h0000FFFF);
        rst = 1'b0;
        #1;
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_ready", 32'(instr_ready), 32'd1);
        chk("t6_rst_alu_a", 32'(alu_a), 32'd0);
        chk_reg("t6_r7_rst", 3'd7, 16'h0000);
        step();
        rst   = 1'b1;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) ndone++;
        end
        chk("t6_no_done", 32'(ndone), 32'd0);
        chk("t6_idle_ready", 32'(instr_ready), 32'd1);
        chk_reg("t6_r7_post", 3'd7, 16'h0000);
        chk_reg("t6_r1_post", 3'd1, 16'h0000);
        chk_flags("t6", 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Sequencer that sits directly upstream of the 16-bit ALU. It holds an 8-entry register file and accepts instructions over a valid/ready handshake. For each instruction it drives the ALU operand and control inputs, captures the ALU result, carry and compare outputs, writes the result back, and maintains status flags. It turns the combinational ALU into a usable execute stage.

Parameters:
DATA_W, 16, datapath and register width; must match the ALU width.
REG_AW, 3, register address width; the file has 2**REG_AW entries.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
instr_valid  input  1  instruction offered.
instr_ready  output  1  high only in IDLE.
instr  input  16  [15]=ldi, [14]=mode, [13:10]=select, [9:7]=rd, [6:4]=ra, [3:1]=rb, [0]=use_carry.
imm_data  input  DATA_W  immediate; sampled with instr when ldi=1.
alu_a  output  DATA_W  ALU operand A (registered).
alu_b  output  DATA_W  ALU operand B (registered).
alu_select  output  4  ALU select (registered).
alu_mode  output  1  ALU mode, 1=logic, 0=arithmetic (registered).
alu_cin  output  1  ALU carry_in (registered).
alu_result  input  DATA_W  ALU result.
alu_cout  input  1  ALU carry_out.
alu_cmp  input  1  ALU compare (A==B).
carry_flag  output  1  last ALU carry.
zero_flag  output  1  last ALU result == 0.
cmp_flag  output  1  last ALU compare.
done  output  1  one-cycle pulse in WB.
dbg_addr  input  REG_AW  debug read address.
dbg_data  output  DATA_W  regfile[dbg_addr], combinational.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers and all ALU drive outputs are cleared to 0.
  - carry_flag, zero_flag, cmp_flag and done are cleared to 0.
  - State goes to IDLE.
  - This applies mid-operation too: an in-flight instruction is dropped with no writeback and no done pulse.
- States are IDLE, OPRD, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On an edge with instr_valid=1, latch the instruction fields (and imm_data if ldi).
  - ldi=0 goes to OPRD; ldi=1 goes to WB.
- OPRD (computational instructions only):
  - Register alu_a=reg[ra], alu_b=reg[rb], alu_select, alu_mode.
  - alu_cin = use_carry ? carry_flag : 0.
  - Go to EXEC.
- EXEC:
  - ALU inputs are stable for the whole cycle.
  - At the closing edge, capture alu_result, alu_cout and alu_cmp into internal registers.
  - Go to WB.
- WB:
  - done=1 for this cycle only.
  - At the closing edge, write reg[rd] with either the captured result or the latched immediate.
  - Computational instructions also update the flags: carry_flag=captured cout, zero_flag=(captured result==0), cmp_flag=captured cmp.
  - ldi leaves all flags unchanged.
  - Go to IDLE.
- Latency and throughput:
  - Computational: accept edge E0; operands visible after E1; result captured at E2; regfile and flags updated at E3.
  - ldi: accept edge E0; write at E1.
  - Throughput is one instruction per 4 cycles (per 2 cycles for ldi).
- instr_ready=0 in OPRD, EXEC and WB. instr_valid asserted in those states is ignored and must be held by the source.
- Source and destination may alias (rd==ra or rd==rb): operands are read in OPRD, before writeback, so the old value is used.
- Register 0 is an ordinary writable register.
- ALU drive outputs hold their last values in IDLE and WB.
- Arithmetic wraps modulo 2**DATA_W. The ALU supplies carry_out; this block never computes it.

Test Plan:
1. Hold rst=0 for 2 cycles, release → instr_ready=1, done=0, all flags 0, dbg_data=0 for every dbg_addr.
2. ldi r1=0xFFFF, ldi r2=0x0001, then mode=0 select=1001 rd=3 ra=1 rb=2 (A+B), using an ALU model → in EXEC alu_a=FFFF and alu_b=0001; after WB r3=0x0000, carry_flag=1, zero_flag=1, cmp_flag=0.
3. Continue from test 2 with ldi r4=0x0010, then select=1001 rd=5 ra=4 rb=4 use_carry=1 → alu_cin=1; r5=0x0021, carry_flag=0, zero_flag=0, cmp_flag=1.
4. mode=1 select=0110 (XOR) rd=6 ra=1 rb=2 → r6=0xFFFE, carry_flag=0, zero_flag=0.
5. Hold instr_valid high continuously across two back-to-back computational instructions → instr_ready is low for 3 cycles after each accept; the second instruction is accepted only in IDLE; exactly two done pulses, 4 cycles apart.
6. Assert rst during EXEC of an instruction targeting r7 (pre-loaded 0x1234) → r7 reads 0 (reset), no done pulse, IDLE with instr_ready=1 after release.
